ps2_rx: RTL and testbench
=========================

# ps2_rx

PS/2 keyboard receiver sitting directly upstream of the input buffer. It deserialises 11-bit PS/2 device frames and folds the E0 (extended) and F0 (break) prefixes into the following byte. It then presents each resulting key event as a nonzero word on `out` for a fixed hold window. The input buffer captures any nonzero `in` on its own sampling tick, and zero means "no data", so this block never drives a nonzero idle value.

## Interface
- `WIDTH`, 16: output word width; must be ≥ 10; bits above 9 are driven 0.
- `HOLD`, 64: clk cycles a decoded word stays on `out`; ≥ 1; must exceed the input buffer's sampling period.
- `TIMEOUT`, 50000: clk cycles without a PS/2 falling edge before a partial frame is aborted; ≥ 2.

- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `ps2_clk`  in  1  raw PS/2 clock pin, asynchronous to `clk`.
- `ps2_data`  in  1  raw PS/2 data pin, asynchronous to `clk`.
- `out`  out  WIDTH  key event: [7:0] scan code, [8] extended, [9] break; 0 means no data.
- `frame_err`  out  1  one-cycle pulse on a rejected or aborted frame.
- `busy`  out  1  high while a frame is being received (state RECV).

## Operation
- Synchronisation:
  - `ps2_clk` and `ps2_data` each pass through a 2-FF synchroniser; both stages reset to 1 (idle-high lines).
  - A falling-edge pulse `fe` asserts when the previous synced clk is 1 and the current is 0.
  - Data is sampled from the synced `ps2_data` on the `fe` cycle.
- State IDLE:
  - `fe` with data 0: start bit accepted; go to RECV with bitcnt = 1.
  - `fe` with data 1: ignored; stay in IDLE.
- State RECV:
  - Each `fe` shifts data into an 11-bit register, LSB first, and increments bitcnt.
  - The idle counter clears on every `fe`. When it reaches TIMEOUT: pulse `frame_err`, clear the prefix flags, go to IDLE.
  - On the `fe` that makes bitcnt = 11, validate start = 0, stop = 1, and odd parity over the 8 data bits plus the parity bit.
- Outcome of validation:
  - Invalid frame: pulse `frame_err`, clear flags, go to IDLE.
  - 8'hE0: set ext, go to IDLE, no output.
  - 8'hF0: set brk, go to IDLE, no output.
  - 8'h00 or 8'hFF (device error codes): discard, clear flags, go to IDLE.
  - Any other byte: `out` = {0, brk, ext, byte}, clear flags, go to HOLD with holdcnt = HOLD.
- State HOLD:
  - `out` is held stable and holdcnt decrements each cycle.
  - At holdcnt = 1 the next cycle drives `out` = 0 and goes to IDLE.
  - `fe` with data 0 during HOLD: `out` goes to 0 next cycle and the block enters RECV with bitcnt = 1, so back-to-back frames are never lost.
- Flags survive between a prefix byte and the following byte. The sequence E0 F0 xx sets both flags.

## Timing
- Reset (async, while `rst_n` = 0): `out` = 0, `frame_err` = 0, `busy` = 0, state IDLE, flags 0, counters 0, sync FFs 1.
- Reset asserted mid-frame aborts the frame silently, with no `frame_err`.
- A raw pin falling edge produces `fe` 3 clk edges later (2 sync stages plus the edge register).
- `out` becomes nonzero on the clk edge following the 11th `fe`. It stays exactly HOLD cycles, then returns to 0.
- `frame_err` goes high on the edge after the validating `fe` or the timeout, for exactly 1 cycle.
- `busy` rises with entry to RECV and falls with its exit.
- If timeout and `fe` coincide in the same cycle, `fe` wins and the counter clears.
- Counter widths: bitcnt is 4 bits; holdcnt is $clog2(HOLD+1) bits; the idle counter is $clog2(TIMEOUT+1) bits and saturates, never wrapping.

## Structure
- Shared package/include `ps2_defs`:
  - State encoding IDLE/RECV/HOLD.
  - Constants PS2_EXT = 8'hE0, PS2_BRK = 8'hF0, PS2_ERR0 = 8'h00, PS2_ERR1 = 8'hFF.
  - Bit positions OUT_EXT = 8, OUT_BRK = 9.
- One sub-module, `ps2_sync_edge`: a 2-FF synchroniser for both pins plus falling-edge detector. It outputs the synced data and `fe`, and is reusable for a future PS/2 mouse port.
- The remainder is the FSM, shift register and counters in `ps2_rx`.

## Test plan
- Make code: frame 0x1C (parity 0, stop 1) -> `out` = 16'h001C for exactly 64 cycles then 0; `frame_err` never high; `busy` high only during the frame.
- Extended make: frames E0, 75 -> no output after E0; `out` = 16'h0175 after 75.
- Break codes:
  - F0, 1C -> 16'h021C.
  - E0, F0, 75 -> 16'h0375.
  - A following plain 1C -> 16'h001C (flags cleared).
- Bad parity: 0x1C sent with parity 1 -> single-cycle `frame_err`, `out` stays 0. Next good 0x1C -> 16'h001C.
- Abort paths:
  - 5 bits sent, then `ps2_clk` held high for TIMEOUT cycles -> `frame_err` pulse, `busy` falls; next full frame 0x29 -> 16'h0029.
  - `rst_n` pulsed low after 6 bits -> all outputs 0 immediately and no `frame_err`; next frame decodes.
- Back-to-back and glitch:
  - Second frame 0x32 starts while holding 0x1C -> `out` drops to 0, then shows 16'h0032.
  - A lone edge with data 1 in IDLE is ignored.

Source files
------------

// File: rtl/ps2_rx_pkg.sv
// Shared definitions for the PS/2 receiver: FSM state encoding, scan-code
// prefix/error constants, output bit positions and the frame check helper.
package ps2_defs;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RECV = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam logic [7:0] PS2_EXT  = 8'hE0;
    localparam logic [7:0] PS2_BRK  = 8'hF0;
    localparam logic [7:0] PS2_ERR0 = 8'h00;
    localparam logic [7:0] PS2_ERR1 = 8'hFF;

    localparam int OUT_EXT = 8;
    localparam int OUT_BRK = 9;

    // Frame layout once all 11 bits are shifted in LSB first:
    // [0] start, [8:1] data, [9] parity, [10] stop.
    // Valid when start = 0, stop = 1 and data+parity has an odd number of ones.
    function automatic logic frame_ok(input logic [10:0] frame);
        return (frame[0] == 1'b0) && (frame[10] == 1'b1) && (^frame[9:1] == 1'b1);
    endfunction

endpackage

// File: rtl/ps2_rx_if.sv
// Bundle of the PS/2 pin inputs and decoded-event outputs of ps2_rx.
// master: the side driving the PS/2 pins and consuming events.
// slave:  the receiver itself.
interface ps2_rx_if #(
    parameter int WIDTH = 16
);
    logic             ps2_clk;
    logic             ps2_data;
    logic [WIDTH-1:0] out;
    logic             frame_err;
    logic             busy;

    modport master (
        output ps2_clk,
        output ps2_data,
        input  out,
        input  frame_err,
        input  busy
    );

    modport slave (
        input  ps2_clk,
        input  ps2_data,
        output out,
        output frame_err,
        output busy
    );
endinterface

// File: rtl/ps2_rx_sync_edge.sv
// Two-flop synchroniser for the PS/2 clock and data pins plus a registered
// falling-edge detector on the synced clock. Data is registered alongside
// the edge pulse so that 'data' is the value present when 'fe' fires.
module ps2_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic data,
    output logic fe
);

    logic [1:0] pin_raw;
    logic [1:0] pin_sync;
    logic       clk_prev_reg;
    logic       fe_reg;
    logic       data_reg;

    assign pin_raw = {ps2_data, ps2_clk};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_sync
            logic meta_reg;
            logic sync_reg;

            // Two-stage synchroniser; lines idle high so reset to 1.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    meta_reg <= 1'b1;
                    sync_reg <= 1'b1;
                end else begin
                    meta_reg <= pin_raw[gi];
                    sync_reg <= meta_reg;
                end
            end

            assign pin_sync[gi] = sync_reg;
        end
    endgenerate

    // Registered falling-edge pulse on the synced clock, with data aligned to it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_prev_reg <= 1'b1;
            fe_reg       <= 1'b0;
            data_reg     <= 1'b1;
        end else begin
            clk_prev_reg <= pin_sync[0];
            fe_reg       <= clk_prev_reg & ~pin_sync[0];
            data_reg     <= pin_sync[1];
        end
    end

    assign fe   = fe_reg;
    assign data = data_reg;

endmodule

// File: rtl/ps2_rx.sv
// PS/2 keyboard receiver: deserialises 11-bit frames, folds E0/F0 prefixes
// into the following scan code and presents each key event on 'out' for a
// fixed number of cycles. Zero on 'out' means no data.
module ps2_rx
    import ps2_defs::*;
#(
    parameter int WIDTH   = 16,
    parameter int HOLD    = 64,
    parameter int TIMEOUT = 50000
) (
    input  logic     clk,
    input  logic     rst_n,
    ps2_rx_if.slave  bus
);

    localparam int HW = $clog2(HOLD + 1);
    localparam int IW = $clog2(TIMEOUT + 1);

    logic             fe;
    logic             data_sync;

    state_t           state_reg;
    logic [3:0]       bitcnt_reg;
    logic [10:0]      shift_reg;
    logic [HW-1:0]    hold_cnt_reg;
    logic [IW-1:0]    idle_cnt_reg;
    logic             ext_reg;
    logic             brk_reg;
    logic [WIDTH-1:0] out_reg;
    logic             frame_err_reg;
    logic             busy_reg;

    logic [10:0]      frame_next;
    logic [7:0]       code_next;
    logic [WIDTH-1:0] event_word;

    ps2_sync_edge u_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .ps2_clk  (bus.ps2_clk),
        .ps2_data (bus.ps2_data),
        .data     (data_sync),
        .fe       (fe)
    );

    // Shift register contents as they will be after the current edge.
    assign frame_next = {data_sync, shift_reg[10:1]};
    assign code_next  = frame_next[8:1];

    // Event word for a completed non-prefix byte, carrying pending flags.
    always_comb begin
        event_word          = '0;
        event_word[7:0]     = code_next;
        event_word[OUT_EXT] = ext_reg;
        event_word[OUT_BRK] = brk_reg;
    end

    // Receive FSM with shift register, bit/idle/hold counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            bitcnt_reg    <= '0;
            shift_reg     <= '0;
            hold_cnt_reg  <= '0;
            idle_cnt_reg  <= '0;
            ext_reg       <= 1'b0;
            brk_reg       <= 1'b0;
            out_reg       <= '0;
            frame_err_reg <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            frame_err_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    idle_cnt_reg <= '0;
                    if (fe && !data_sync) begin
                        state_reg  <= ST_RECV;
                        busy_reg   <= 1'b1;
                        bitcnt_reg <= 4'd1;
                        shift_reg  <= frame_next;
                    end
                end

                ST_RECV: begin
                    if (fe) begin
                        // An edge always wins over a coincident timeout.
                        idle_cnt_reg <= '0;
                        shift_reg    <= frame_next;
                        bitcnt_reg   <= bitcnt_reg + 4'd1;
                        if (bitcnt_reg == 4'd10) begin
                            state_reg  <= ST_IDLE;
                            busy_reg   <= 1'b0;
                            bitcnt_reg <= '0;
                            if (!frame_ok(frame_next)) begin
                                frame_err_reg <= 1'b1;
                                ext_reg       <= 1'b0;
                                brk_reg       <= 1'b0;
                            end else if (code_next == PS2_EXT) begin
                                ext_reg <= 1'b1;
                            end else if (code_next == PS2_BRK) begin
                                brk_reg <= 1'b1;
                            end else if (code_next == PS2_ERR0 || code_next == PS2_ERR1) begin
                                ext_reg <= 1'b0;
                                brk_reg <= 1'b0;
                            end else begin
                                out_reg      <= event_word;
                                ext_reg      <= 1'b0;
                                brk_reg      <= 1'b0;
                                hold_cnt_reg <= HW'(HOLD);
                                state_reg    <= ST_HOLD;
                            end
                        end
                    end else if (idle_cnt_reg == IW'(TIMEOUT)) begin
                        frame_err_reg <= 1'b1;
                        ext_reg       <= 1'b0;
                        brk_reg       <= 1'b0;
                        state_reg     <= ST_IDLE;
                        busy_reg      <= 1'b0;
                        bitcnt_reg    <= '0;
                        idle_cnt_reg  <= '0;
                    end else begin
                        idle_cnt_reg <= idle_cnt_reg + IW'(1);
                    end
                end

                ST_HOLD: begin
                    if (fe && !data_sync) begin
                        // A new start bit cuts the hold short so no frame is lost.
                        out_reg      <= '0;
                        hold_cnt_reg <= '0;
                        state_reg    <= ST_RECV;
                        busy_reg     <= 1'b1;
                        bitcnt_reg   <= 4'd1;
                        shift_reg    <= frame_next;
                        idle_cnt_reg <= '0;
                    end else if (hold_cnt_reg == HW'(1)) begin
                        out_reg      <= '0;
                        hold_cnt_reg <= '0;
                        state_reg    <= ST_IDLE;
                    end else begin
                        hold_cnt_reg <= hold_cnt_reg - HW'(1);
                    end
                end

                default: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                    out_reg   <= '0;
                end
            endcase
        end
    end

    assign bus.out       = out_reg;
    assign bus.frame_err = frame_err_reg;
    assign bus.busy      = busy_reg;

endmodule

// File: tb/tb_ps2_rx.sv
// Directed testbench for ps2_rx: drives PS/2 frames on the pins and checks
// decoded words, hold length, error pulses and busy against hand-computed values.
module tb_ps2_rx;

    localparam int WIDTH   = 16;
    localparam int HOLD    = 64;
    localparam int TIMEOUT = 300;
    localparam int HALF    = 20;

    logic clk;
    logic rst_n;

    ps2_rx_if #(.WIDTH(WIDTH)) bus ();

    ps2_rx #(
        .WIDTH   (WIDTH),
        .HOLD    (HOLD),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [WIDTH-1:0] words[$];
    int               runs[$];
    int               run_len    = 0;
    int               err_cycles = 0;

    // Log each nonzero run on out (value and length) and count error cycles.
    always @(negedge clk) begin
        if (bus.out != '0) begin
            if (run_len == 0) words.push_back(bus.out);
            run_len++;
        end else if (run_len != 0) begin
            runs.push_back(run_len);
            run_len = 0;
        end
        if (bus.frame_err) err_cycles++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] word_at(input int idx);
        if (idx < words.size()) return 32'(words[idx]);
        return 32'hDEAD;
    endfunction

    function automatic int run_at(input int idx);
        if (idx < runs.size()) return runs[idx];
        return -1;
    endfunction

    function automatic logic [10:0] make_frame(input logic [7:0] b, input logic flip_par);
        return {1'b1, (~^b) ^ flip_par, b, 1'b0};
    endfunction

    task automatic ps2_bit(input logic b);
        bus.ps2_data = b;
        repeat (HALF) @(negedge clk);
        bus.ps2_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        bus.ps2_clk = 1'b1;
    endtask

    task automatic send_bits(input logic [10:0] f, input int lo, input int hi);
        for (int i = lo; i < hi; i++) ps2_bit(f[i]);
        bus.ps2_data = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_bits(make_frame(b, 1'b0), 0, 11);
        $display("sent frame %02h", b);
    endtask

    task automatic settle();
        repeat (HOLD + 30) @(negedge clk);
    endtask

    task automatic clear_log();
        words.delete();
        runs.delete();
        err_cycles = 0;
    endtask

    initial begin
        rst_n        = 1'b0;
        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_out",  32'(bus.out),       32'h0);
        check("reset_err",  32'(bus.frame_err), 32'h0);
        check("reset_busy", 32'(bus.busy),      32'h0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        clear_log();

        // Plain make code 1C, busy observed mid-frame.
        send_bits(make_frame(8'h1C, 1'b0), 0, 5);
        repeat (5) @(negedge clk);
        check("make_busy_mid", 32'(bus.busy), 32'h1);
        send_bits(make_frame(8'h1C, 1'b0), 5, 11);
        $display("sent frame 1c");
        settle();
        check("make_count", 32'(words.size()), 32'd1);
        check("make_word",  word_at(0),        32'h001C);
        check("make_hold",  32'(run_at(0)),    32'd64);
        check("make_err",   32'(err_cycles),   32'd0);
        check("make_busy_end", 32'(bus.busy),  32'h0);
        clear_log();

        // Extended make: E0 alone gives nothing.
        send_byte(8'hE0);
        repeat (20) @(negedge clk);
        check("ext_prefix_silent", 32'(words.size()), 32'd0);
        send_byte(8'h75);
        settle();
        check("ext_word", word_at(0), 32'h0175);
        clear_log();

        // Break, extended break, then flags cleared.
        send_byte(8'hF0);
        send_byte(8'h1C);
        settle();
        check("brk_word", word_at(0), 32'h021C);
        clear_log();
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h75);
        settle();
        check("ext_brk_word", word_at(0), 32'h0375);
        clear_log();
        send_byte(8'h1C);
        settle();
        check("flags_cleared", word_at(0), 32'h001C);
        clear_log();

        // Bad parity.
        send_bits(make_frame(8'h1C, 1'b1), 0, 11);
        $display("sent frame 1c with bad parity");
        settle();
        check("parity_err_pulse", 32'(err_cycles),   32'd1);
        check("parity_no_out",    32'(words.size()), 32'd0);
        clear_log();
        send_byte(8'h1C);
        settle();
        check("parity_recover", word_at(0), 32'h001C);
        clear_log();

        // Device error code is discarded.
        send_byte(8'hFF);
        settle();
        check("errcode_no_out", 32'(words.size()), 32'd0);
        check("errcode_no_err", 32'(err_cycles),   32'd0);
        clear_log();

        // Timeout abort after 5 bits.
        send_bits(make_frame(8'h29, 1'b0), 0, 5);
        $display("sent partial frame, 5 bits");
        repeat (TIMEOUT + 30) @(negedge clk);
        check("timeout_err",  32'(err_cycles), 32'd1);
        check("timeout_busy", 32'(bus.busy),   32'h0);
        clear_log();
        send_byte(8'h29);
        settle();
        check("timeout_recover", word_at(0), 32'h0029);
        clear_log();

        // Reset mid-frame after 6 bits.
        send_bits(make_frame(8'h4D, 1'b0), 0, 6);
        $display("sent partial frame, 6 bits, then reset");
        rst_n = 1'b0;
        #1;
        check("rst_mid_out",  32'(bus.out),       32'h0);
        check("rst_mid_busy", 32'(bus.busy),      32'h0);
        check("rst_mid_err",  32'(bus.frame_err), 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_mid_no_err", 32'(err_cycles), 32'd0);
        send_byte(8'h4D);
        settle();
        check("rst_recover", word_at(0), 32'h004D);
        clear_log();

        // Back-to-back frames cut the hold short.
        send_byte(8'h1C);
        send_byte(8'h32);
        settle();
        check("b2b_count",   32'(words.size()), 32'd2);
        check("b2b_first",   word_at(0),        32'h001C);
        check("b2b_second",  word_at(1),        32'h0032);
        check("b2b_cut",     32'(run_at(0) > 0 && run_at(0) < HOLD), 32'd1);
        check("b2b_full",    32'(run_at(1)),    32'd64);
        clear_log();

        // Lone falling edge with data high in IDLE is ignored.
        bus.ps2_data = 1'b1;
        repeat (HALF) @(negedge clk);
        bus.ps2_clk = 1'b0;
        repeat (8) @(negedge clk);
        check("glitch_busy", 32'(bus.busy), 32'h0);
        bus.ps2_clk = 1'b1;
        $display("sent lone edge with data high");
        settle();
        check("glitch_no_out", 32'(words.size()), 32'd0);
        check("glitch_no_err", 32'(err_cycles),   32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
